// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL bring-up sequencer in the 50 MHz reference domain.
// Ports:
//   clk_50mhz    reference clock (also the PLL refclk)
//   reset_N      asynchronous active-low reset
//   pll_locked   PLL lock indication, asynchronous, synchronised internally
//   soft_restart single-cycle pulse forcing a fresh bring-up from any state
//   pll_rst      active-high PLL reset
//   sys_rst_n    registered active-low datapath reset, released only in RUN
//   pll_ready    high while in RUN
//   lock_err     sticky failure flag, high in FAIL
//   retry_cnt    failed attempts since last RUN/restart, saturates at MAX_RETRY
//   lost_cnt     loss-of-lock events seen in RUN, saturates at 255
//   state        FSM state: PLL_RST=0 WAIT_LOCK=1 STABLE=2 RUN=3 LOST=4 FAIL=5
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk_50mhz,
    input  logic       reset_N,
    input  logic       pll_locked,
    input  logic       soft_restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_err,
    output logic [1:0] retry_cnt,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RTY_MAX  = 2'(MAX_RETRY);

    state_t           st, st_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       retry_d;
    logic [7:0]       lost_d;
    logic             sync1, lock_s, attempt_fail;

    always_comb begin
        st_d         = st;
        cnt_d        = cnt + 1'b1;
        retry_d      = retry_cnt;
        lost_d       = lost_cnt;
        attempt_fail = 1'b0;
        if (soft_restart) begin
            st_d    = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (st)
                PLL_RST: if (cnt == RST_LAST) begin
                    st_d  = WAIT_LOCK;
                    cnt_d = '0;
                end
                WAIT_LOCK: if (lock_s) begin
                    st_d  = STABLE;
                    cnt_d = '0;
                end else if (cnt == TO_LAST) begin
                    attempt_fail = 1'b1;
                end
                STABLE: if (!lock_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt == STB_LAST) begin
                    st_d    = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        st_d   = LOST;
                        lost_d = lost_cnt + 8'(lost_cnt != 8'hff);
                    end
                end
                LOST: begin
                    st_d  = PLL_RST;
                    cnt_d = '0;
                end
                FAIL: cnt_d = '0;
                default: begin
                    st_d  = PLL_RST;
                    cnt_d = '0;
                end
            endcase
            // The final tolerated failure parks in FAIL with retry_cnt at its bound.
            if (attempt_fail) begin
                cnt_d   = '0;
                retry_d = retry_cnt + 2'd1;
                st_d    = (retry_d == RTY_MAX) ? FAIL : PLL_RST;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk_50mhz or negedge reset_N) begin
        if (!reset_N) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            st        <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            lost_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            sync1     <= pll_locked;
            lock_s    <= sync1;
            st        <= st_d;
            cnt       <= cnt_d;
            retry_cnt <= retry_d;
            lost_cnt  <= lost_d;
            pll_rst   <= (st_d == PLL_RST) || (st_d == FAIL);
            sys_rst_n <= (st_d == RUN);
            pll_ready <= (st_d == RUN);
            lock_err  <= (st_d == FAIL);
        end
    end

    assign state = st;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench for pll_reset_ctrl against a phase/elapsed-time model.
module tb_pll_reset_ctrl;
    localparam int RC = 4, LT = 20, SC = 8, MR = 2;
    typedef logic [16:0] obs_t;

    logic       clk = 1'b0, reset_N = 1'b0, pll_locked = 1'b0, soft_restart = 1'b0;
    logic       pll_rst, sys_rst_n, pll_ready, lock_err;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    pll_reset_ctrl #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRY(MR), .CNT_W(16)
    ) dut (
        .clk_50mhz(clk), .reset_N(reset_N), .pll_locked(pll_locked), .soft_restart(soft_restart),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .pll_ready(pll_ready), .lock_err(lock_err),
        .retry_cnt(retry_cnt), .lost_cnt(lost_cnt), .state(state)
    );

    always #10 clk = ~clk;

    int   n_cmp = 0, n_bad = 0;
    obs_t q[$];
    int   ph, t, m_retry, m_lost;
    bit   hist[$];

    function automatic obs_t dut_obs();
        return {state, pll_rst, sys_rst_n, pll_ready, lock_err, retry_cnt, lost_cnt};
    endfunction

    function automatic obs_t exp_obs();
        return {3'(ph), 1'(ph == 0 || ph == 5), 1'(ph == 3), 1'(ph == 3), 1'(ph == 5),
                2'(m_retry), 8'(m_lost)};
    endfunction

    function automatic void report(string name, obs_t a, obs_t e);
        $display("FAIL %s @%0t: got st=%0d prst=%b srn=%b rdy=%b err=%b rty=%0d lost=%0d, expected st=%0d prst=%b srn=%b rdy=%b err=%b rty=%0d lost=%0d",
                 name, $time, a[16:14], a[13], a[12], a[11], a[10], a[9:8], a[7:0],
                 e[16:14], e[13], e[12], e[11], e[10], e[9:8], e[7:0]);
    endfunction

    function automatic void model_reset();
        ph = 0; t = 0; m_retry = 0; m_lost = 0;
        hist = '{1'b0, 1'b0};
    endfunction

    function automatic void attempt_failed();
        m_retry++;
        ph = (m_retry == MR) ? 5 : 0;
        t = 0;
    endfunction

    // Phase 0..5 follow the encoded states; t is cycles already spent in the phase.
    function automatic void model_step(bit lk, bit sr);
        bit ls;
        ls = hist.pop_front();
        hist.push_back(lk);
        if (sr) begin
            ph = 0; t = 0; m_retry = 0;
        end else case (ph)
            0: begin t++; if (t == RC) begin ph = 1; t = 0; end end
            1: begin
                t++;
                if (ls) begin ph = 2; t = 0; end
                else if (t == LT) attempt_failed();
            end
            2: if (!ls) attempt_failed();
               else begin t++; if (t == SC) begin ph = 3; m_retry = 0; end end
            3: if (!ls) begin ph = 4; if (m_lost < 255) m_lost++; end
            4: begin ph = 0; t = 0; end
            default: ;
        endcase
    endfunction

    task automatic step(input bit rn, input bit lk, input bit sr);
        @(negedge clk);
        reset_N = rn; pll_locked = lk; soft_restart = sr;
        if (rn) model_step(lk, sr); else model_reset();
        q.push_back(exp_obs());
    endtask

    task automatic steps(input int n, input bit lk);
        for (int i = 0; i < n; i++) step(1'b1, lk, 1'b0);
    endtask

    task automatic async_rst();
        obs_t a;
        @(negedge clk);
        #3 reset_N = 1'b0;
        #1 a = dut_obs();
        model_reset();
        q.delete();
        n_cmp++;
        if (a !== exp_obs()) begin n_bad++; report("async_reset", a, exp_obs()); end
    endtask

    initial forever begin
        obs_t e, a;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = dut_obs();
            n_cmp++;
            if (a !== e) begin n_bad++; report("scoreboard", a, e); end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        // nominal bring-up
        steps(10, 1'b0);
        steps(30, 1'b1);
        // loss of lock in RUN
        steps(3, 1'b0);
        steps(30, 1'b1);
        // unstable lock during STABLE
        step(1'b1, 1'b0, 1'b1);
        steps(6, 1'b0);
        steps(5, 1'b1);
        steps(10, 1'b0);
        steps(40, 1'b1);
        // two timeouts into FAIL
        steps(60, 1'b0);
        // recovery from FAIL
        step(1'b1, 1'b1, 1'b1);
        steps(40, 1'b1);
        // drive lost_cnt to saturation
        for (int i = 0; i < 270; i++) begin
            steps(20, 1'b1);
            steps(2, 1'b0);
        end
        steps(30, 1'b1);
        // asynchronous reset in STABLE and in RUN
        step(1'b1, 1'b1, 1'b1);
        steps(9, 1'b1);
        async_rst();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
        steps(40, 1'b1);
        async_rst();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        // randomized lock patterns with occasional restarts and resets
        for (int s = 0; s < 150; s++) begin
            bit lk;
            int len;
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) step(1'b1, lk, $urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0) begin
                async_rst();
                step(1'b0, lk, 1'b0);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
